// File: rtl/uart_rx_os16.sv
// 16x-oversampled 8N1 UART receiver: synchronises rx, qualifies the start bit at
// mid-bit, samples each data bit at its centre and flags a low stop bit.
module uart_rx_os16 #(
   parameter int DATA_BITS = 8,
   parameter int OS_RATE   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 br_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int TW = $clog2(OS_RATE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] TICK_MID  = TW'(OS_RATE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OS_RATE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic                 rx_meta_q;
   logic                 rx_s_q;
   logic [1:0]           state_q,     state_d;
   logic [TW-1:0]        tick_cnt_q,  tick_cnt_d;
   logic [BW-1:0]        bit_cnt_q,   bit_cnt_d;
   logic [DATA_BITS-1:0] shift_reg_q, shift_reg_d;
   logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
   logic                 rx_done_q,   rx_done_d;
   logic                 frame_err_q, frame_err_d;

   // Both synchroniser stages reset to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_reg_d = shift_reg_q;
      rx_data_d   = rx_data_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d    = START;
               tick_cnt_d = '0;
            end
         end
         START: begin
            if (br_tick) begin
               if (tick_cnt_q == TICK_MID) begin
                  tick_cnt_d = '0;
                  // A start bit that is high again at its centre was a glitch.
                  if (!rx_s_q) begin
                     bit_cnt_d = '0;
                     state_d   = DATA;
                  end else begin
                     state_d   = IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (br_tick) begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d  = '0;
                  shift_reg_d = {rx_s_q, shift_reg_q[DATA_BITS-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d = STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            // Finishing at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
            if (br_tick) begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = '0;
                  state_d    = IDLE;
                  if (rx_s_q) begin
                     rx_data_d = shift_reg_q;
                     rx_done_d = 1'b1;
                  end else begin
                     frame_err_d = 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_reg_q <= '0;
         rx_data_q   <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_reg_q <= shift_reg_d;
         rx_data_q   <= rx_data_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_done   = rx_done_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: table of single frames plus hand-written
// back-to-back, glitch, mid-frame reset, tick-aligned loopback and idle-low sequences.
module tb_uart_rx_os16;

   logic       clk;
   logic       reset;
   logic       br_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       busy;

   int checks;
   int failures;

   int         done_cnt;
   int         err_cnt;
   logic [7:0] done_log [64];
   longint     done_t   [64];
   int         tick_div;

   uart_rx_os16 #(.DATA_BITS(8), .OS_RATE(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .br_tick  (br_tick),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .frame_err(frame_err),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One br_tick every 10 clk, updated on the falling edge.
   initial begin
      tick_div = 0;
      br_tick  = 1'b0;
   end
   always @(negedge clk) begin
      tick_div = (tick_div == 9) ? 0 : tick_div + 1;
      br_tick  = (tick_div == 0);
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Pulse monitor: logs every done, counts errors, and checks pulse exclusivity and busy.
   always @(negedge clk) begin
      if (rx_done || frame_err) begin
         chk("pulse_exclusive", int'(rx_done & frame_err), 0);
         chk("busy_low_on_pulse", int'(busy), 0);
      end
      if (rx_done) begin
         if (done_cnt < 64) begin
            done_log[done_cnt] = rx_data;
            done_t[done_cnt]   = $time;
         end
         done_cnt++;
      end
      if (frame_err) err_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Clock-timed frame: 160 clk per bit; a bad stop bit is held low for 100 clk only.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      rx = 1'b0;
      wait_clk(160);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_clk(160);
      end
      rx = stop;
      if (stop) begin
         wait_clk(160);
      end else begin
         wait_clk(100);
         rx = 1'b1;
         wait_clk(60);
      end
   endtask

   task automatic wait_ticks(input int n);
      int k;
      k = 0;
      while (k < n) begin
         @(posedge clk);
         if (br_tick) k++;
      end
      @(negedge clk);
   endtask

   // Tick-aligned transmitter model sharing br_tick with the receiver.
   task automatic tx_byte(input logic [7:0] d);
      logic [9:0] frame;
      frame = {1'b1, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         wait_ticks(16);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_done;
      int         exp_err;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int d0, e0, n;
      longint gap;
      checks   = 0;
      failures = 0;
      done_cnt = 0;
      err_cnt  = 0;

      vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
      vecs[1] = '{8'h12, 1'b1, 1, 0, 8'h12};
      vecs[2] = '{8'hC4, 1'b0, 0, 1, 8'h12};
      vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
      vecs[5] = '{8'h80, 1'b0, 0, 1, 8'hFF};
      vecs[6] = '{8'h01, 1'b1, 1, 0, 8'h01};

      rx    = 1'b1;
      reset = 1'b1;
      wait_clk(5);
      chk("reset_rx_data", rx_data, 0);
      chk("reset_rx_done", rx_done, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_busy", busy, 0);
      reset = 1'b0;
      wait_clk(50);

      for (int v = 0; v < 7; v++) begin
         d0 = done_cnt;
         e0 = err_cnt;
         send_frame(vecs[v].data, vecs[v].stop);
         wait_clk(300);
         chk($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_done);
         chk($sformatf("vec%0d_err", v), err_cnt - e0, vecs[v].exp_err);
         chk($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
      end

      // Back-to-back frames with no idle gap.
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(8'hA3, 1'b1);
      send_frame(8'h0F, 1'b1);
      wait_clk(300);
      chk("b2b_done_count", done_cnt - d0, 2);
      chk("b2b_err_count", err_cnt - e0, 0);
      if (done_cnt - d0 == 2 && done_cnt <= 64) begin
         chk("b2b_first", done_log[d0], 8'hA3);
         chk("b2b_second", done_log[d0 + 1], 8'h0F);
         gap = (done_t[d0 + 1] - done_t[d0]) / 10;
         chk("b2b_gap_in_range", longint'(gap >= 1580 && gap <= 1620), 1);
      end
      chk("b2b_rx_data", rx_data, 8'h0F);

      // Start-bit glitch: 30 clk low, rejected at tick 7.
      d0 = done_cnt;
      e0 = err_cnt;
      rx = 1'b0;
      wait_clk(30);
      chk("glitch_busy_high", busy, 1);
      rx = 1'b1;
      n = 0;
      while (busy && n < 200) begin
         wait_clk(1);
         n++;
      end
      chk("glitch_busy_falls", busy, 0);
      chk("glitch_busy_fall_time", longint'(n >= 20 && n <= 80), 1);
      wait_clk(300);
      chk("glitch_no_done", done_cnt - d0, 0);
      chk("glitch_no_err", err_cnt - e0, 0);
      chk("glitch_rx_data", rx_data, 8'h0F);

      // Reset after data bit 3 of 0xFF.
      d0 = done_cnt;
      rx = 1'b0;
      wait_clk(160);
      rx = 1'b1;
      wait_clk(640);
      chk("midreset_busy_before", busy, 1);
      reset = 1'b1;
      #1;
      chk("midreset_rx_data", rx_data, 0);
      chk("midreset_busy", busy, 0);
      chk("midreset_done", rx_done, 0);
      chk("midreset_err", frame_err, 0);
      wait_clk(3);
      reset = 1'b0;
      wait_clk(1200);
      chk("midreset_no_done", done_cnt - d0, 0);
      send_frame(8'h81, 1'b1);
      wait_clk(300);
      chk("after_reset_done", done_cnt - d0, 1);
      chk("after_reset_data", rx_data, 8'h81);

      // Loopback from a br_tick-driven transmitter.
      d0 = done_cnt;
      e0 = err_cnt;
      tx_byte(8'h3C);
      wait_clk(200);
      chk("loop_done", done_cnt - d0, 1);
      chk("loop_err", err_cnt - e0, 0);
      chk("loop_data", rx_data, 8'h3C);

      // Idle-low line: repeated framing errors, then normal reception once released.
      d0 = done_cnt;
      e0 = err_cnt;
      rx = 1'b0;
      wait_clk(3300);
      chk("idlelow_errs", err_cnt - e0, 2);
      chk("idlelow_no_done", done_cnt - d0, 0);
      rx = 1'b1;
      wait_clk(2000);
      send_frame(8'h5A, 1'b1);
      wait_clk(300);
      chk("idlelow_recover_data", rx_data, 8'h5A);
      chk("idlelow_recover_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
